skip_counter_ctrl: RTL and testbench

//  Controller/sequencer for a WIDTH-bit skip-sequence counter built from JK flip-flops.
//  - Run control: start, stop (pause), resume, single-step, abort.
//  - Programmable wrap value and skip set (e.g. limit=6, skip {3} -> 0,1,2,4,5,6,0).
//  - Bounded-length runs with done/wrap status.
//  - Sits between the lab control logic (switches/FSM) and the counter flip-flop bank.

---
 rtl/skip_counter_pkg.sv | 17 +
 rtl/jk_cell.sv | 30 +++
 rtl/skip_counter_ctrl.sv | 150 +++++++++++++++
 tb/tb_skip_counter_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/skip_counter_pkg.sv
// Shared types and defaults for the skip-sequence counter controller.
package skip_counter_pkg;

  localparam int unsigned DEF_WIDTH = 3;
  localparam int unsigned DEF_CNT_W = 8;

  // Lab sequence 0,1,2,4,5,6 with limit 7: states 3 and 7 skipped.
  localparam logic [7:0] DEF_SKIP_MASK = 8'h88;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop of the counter bank, with synchronous active-high clear.
module jk_cell (
  input  logic clk,
  input  logic clear,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = q_q;
    case ({j, k})
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/skip_counter_ctrl.sv
// Run-control sequencer for a JK-flip-flop skip counter: start/pause/step/abort,
// programmable wrap value and skip set, bounded run length with done/wrap pulses.
module skip_counter_ctrl
  import skip_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  step,
  input  logic [WIDTH-1:0]      limit,
  input  logic [2**WIDTH-1:0]   skip_mask,
  input  logic [CNT_W-1:0]      run_len,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  wrap,
  output logic                  done
);

  localparam int unsigned NSTATES = 2 ** WIDTH;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     limit_q, limit_d;
  logic [NSTATES-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]     rem_q, rem_d;
  logic                 busy_q, busy_d;
  logic                 wrap_q, wrap_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     count_q;
  logic [WIDTH-1:0]     nxt_c;
  logic                 found;
  logic                 adv;
  logic                 load;
  logic [WIDTH-1:0]     cnt_tgt;
  logic [WIDTH-1:0]     jk_j;
  logic [WIDTH-1:0]     jk_k;

  // next(): smallest non-skipped state in (count, limit], else 0.
  always_comb begin
    nxt_c = '0;
    found = 1'b0;
    for (int unsigned v = 0; v < NSTATES; v++) begin
      if (!found && (WIDTH'(v) > count_q) && (WIDTH'(v) <= limit_q) &&
          !mask_q[WIDTH'(v)]) begin
        nxt_c = WIDTH'(v);
        found = 1'b1;
      end
    end
  end

  // Run-control FSM, run-length bookkeeping and status pulses.
  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    mask_d  = mask_q;
    rem_d   = rem_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    adv     = 1'b0;
    load    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          load    = 1'b1;
          limit_d = limit;
          mask_d  = skip_mask;
          rem_d   = run_len;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) state_d = ST_PAUSE;
        else      adv     = 1'b1;
      end
      ST_PAUSE: begin
        if (stop)       state_d = ST_IDLE;
        else if (start) state_d = ST_RUN;
        else if (step)  adv     = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A zero run length means free-run: rem never reaches 0 by decrement.
    if (adv) begin
      wrap_d = (nxt_c == '0);
      if (rem_q != '0) begin
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
  end

  // Drive JK inputs toward the target so the bank lands on it in one edge.
  always_comb begin
    cnt_tgt = load ? '0 : nxt_c;
    jk_j    = '0;
    jk_k    = '0;
    if (adv || load) begin
      jk_j = ~count_q & cnt_tgt;
      jk_k = count_q & ~cnt_tgt;
    end
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    jk_cell u_jk (
      .clk   (clk),
      .clear (clear),
      .j     (jk_j[i]),
      .k     (jk_k[i]),
      .q     (count_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_IDLE;
      limit_q <= '0;
      mask_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      mask_q  <= mask_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign wrap  = wrap_q;
  assign done  = done_q;

endmodule

// File: tb/tb_skip_counter_ctrl.sv
// Directed vector bench for skip_counter_ctrl.
module tb_skip_counter_ctrl;
  import skip_counter_pkg::*;

  logic       clk = 1'b0;
  logic       clear, start, stop, step;
  logic [2:0] limit;
  logic [7:0] skip_mask;
  logic [7:0] run_len;
  logic [2:0] count;
  logic       busy, wrap, done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       clr, st, sp, stp;
    logic [2:0] lim;
    logic [7:0] msk;
    logic [7:0] rl;
    logic [2:0] e_cnt;
    logic       e_busy, e_wrap, e_done;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] cfg_lim;
  logic [7:0] cfg_msk;
  logic [7:0] cfg_rl;

  skip_counter_ctrl #(.WIDTH(3), .CNT_W(8)) dut (
    .clk       (clk),
    .clear     (clear),
    .start     (start),
    .stop      (stop),
    .step      (step),
    .limit     (limit),
    .skip_mask (skip_mask),
    .run_len   (run_len),
    .count     (count),
    .busy      (busy),
    .wrap      (wrap),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [2:0] ec, input logic eb,
                         input logic ew, input logic ed);
    chk({name, ".count"}, 8'(count), 8'(ec));
    chk({name, ".busy"},  8'(busy),  8'(eb));
    chk({name, ".wrap"},  8'(wrap),  8'(ew));
    chk({name, ".done"},  8'(done),  8'(ed));
  endtask

  task automatic add(input logic clr, input logic st, input logic sp, input logic stp,
                     input logic [2:0] ec, input logic eb, input logic ew, input logic ed);
    vec_t v;
    v.clr = clr; v.st = st; v.sp = sp; v.stp = stp;
    v.lim = cfg_lim; v.msk = cfg_msk; v.rl = cfg_rl;
    v.e_cnt = ec; v.e_busy = eb; v.e_wrap = ew; v.e_done = ed;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic clr, input logic st, input logic sp, input logic stp);
    clear = clr; start = st; stop = sp; step = stp;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    limit = '0; skip_mask = '0; run_len = '0;

    cfg_lim = 3'd6; cfg_msk = 8'h08; cfg_rl = 8'd0;
    //   clr st sp stp   cnt busy wrap done
    add(1, 0, 0, 0,   0, 0, 0, 0);   // reset
    add(0, 1, 0, 0,   0, 1, 0, 0);   // start: no advance
    add(0, 0, 0, 0,   1, 1, 0, 0);
    add(0, 0, 0, 0,   2, 1, 0, 0);
    add(0, 0, 0, 0,   4, 1, 0, 0);   // 3 skipped
    add(0, 0, 0, 0,   5, 1, 0, 0);
    add(0, 0, 0, 0,   6, 1, 0, 0);
    add(0, 0, 0, 0,   0, 1, 1, 0);   // wrap
    add(0, 0, 0, 1,   1, 1, 0, 0);   // step ignored in RUN
    add(0, 0, 0, 0,   2, 1, 0, 0);
    add(0, 0, 1, 0,   2, 1, 0, 0);   // pause, no advance
    add(0, 0, 0, 1,   4, 1, 0, 0);   // step
    add(0, 0, 0, 1,   5, 1, 0, 0);   // step
    add(0, 0, 0, 0,   5, 1, 0, 0);   // held
    add(0, 1, 0, 1,   5, 1, 0, 0);   // resume beats step, no advance
    add(0, 0, 0, 0,   6, 1, 0, 0);
    add(0, 0, 0, 0,   0, 1, 1, 0);
    add(0, 0, 1, 0,   0, 1, 0, 0);   // pause
    add(0, 0, 1, 0,   0, 0, 0, 0);   // abort to IDLE
    add(0, 0, 1, 1,   0, 0, 0, 0);   // stop/step ignored in IDLE
    cfg_lim = 3'd7; cfg_msk = 8'h00; cfg_rl = 8'd5;
    add(0, 1, 0, 0,   0, 1, 0, 0);
    add(0, 0, 0, 0,   1, 1, 0, 0);
    add(0, 0, 0, 0,   2, 1, 0, 0);
    add(0, 0, 0, 0,   3, 1, 0, 0);
    add(0, 0, 0, 0,   4, 1, 0, 0);
    add(0, 0, 0, 0,   5, 0, 0, 1);   // done
    add(0, 0, 0, 0,   5, 0, 0, 0);   // DONE -> IDLE
    add(0, 0, 0, 1,   5, 0, 0, 0);
    cfg_lim = 3'd6; cfg_msk = 8'h08; cfg_rl = 8'd0;
    add(0, 1, 1, 0,   0, 1, 0, 0);   // start+stop in IDLE: run starts
    add(0, 0, 0, 0,   1, 1, 0, 0);
    add(0, 1, 1, 0,   1, 1, 0, 0);   // start+stop in RUN: pause
    add(0, 0, 0, 0,   1, 1, 0, 0);
    add(0, 1, 0, 0,   1, 1, 0, 0);
    add(0, 0, 0, 0,   2, 1, 0, 0);
    add(0, 0, 1, 1,   2, 1, 0, 0);   // stop beats step in RUN
    add(0, 1, 1, 1,   2, 0, 0, 0);   // stop beats start in PAUSE

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].st, vecs[i].sp, vecs[i].stp);
      limit = vecs[i].lim; skip_mask = vecs[i].msk; run_len = vecs[i].rl;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_busy,
              vecs[i].e_wrap, vecs[i].e_done);
    end

    // Clear mid-run at count 5 overrides start/step.
    limit = 3'd6; skip_mask = 8'h08; run_len = 8'd0;
    drive(0, 1, 0, 0); tick();
    drive(0, 0, 0, 0);
    repeat (4) tick();
    chk_all("pre_clear", 3'd5, 1'b1, 1'b0, 1'b0);
    drive(1, 1, 0, 1); tick();
    chk_all("clear_mid", 3'd0, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 0, 0); tick();
    chk_all("post_clear", 3'd0, 1'b0, 1'b0, 1'b0);

    // Step drives run length to 0 from PAUSE, then restart straight from DONE.
    limit = 3'd7; skip_mask = 8'h00; run_len = 8'd2;
    drive(0, 1, 0, 0); tick();
    drive(0, 0, 1, 0); tick();
    chk_all("plen_pause", 3'd0, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 0, 1); tick();
    chk_all("plen_step1", 3'd1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("plen_step2", 3'd2, 1'b0, 1'b0, 1'b1);
    drive(0, 1, 0, 0); tick();
    chk_all("done_restart", 3'd0, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 1, 0); tick(); tick();
    chk_all("restart_abort", 3'd0, 1'b0, 1'b0, 1'b0);

    // limit = 0: count stays 0, wrap every advance.
    limit = 3'd0; skip_mask = 8'h00; run_len = 8'd0;
    drive(0, 1, 0, 0); tick();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("lim0_%0d", i), 3'd0, 1'b1, 1'b1, 1'b0);
    end
    drive(0, 0, 1, 0); tick(); tick();

    // All non-zero states skipped.
    limit = 3'd7; skip_mask = 8'hFE;
    drive(0, 1, 0, 0); tick();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_all($sformatf("maskfe_%0d", i), 3'd0, 1'b1, 1'b1, 1'b0);
    end
    drive(0, 0, 1, 0); tick(); tick();

    // Lab default mask; config inputs change mid-run and must not take effect.
    begin
      logic [2:0] seq [6];
      seq = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd0};
      limit = 3'd7; skip_mask = DEF_SKIP_MASK; run_len = 8'd0;
      drive(0, 1, 0, 0); tick();
      drive(0, 0, 0, 0);
      limit = 3'd3; skip_mask = 8'h00; run_len = 8'd2;
      for (int i = 0; i < 6; i++) begin
        tick();
        chk_all($sformatf("cfgfix_%0d", i), seq[i], 1'b1, (i == 5), 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
